tt_dot_sequencer: RTL and testbench

//  Sequences one shared MAC datapath through a dot product of length LEN: latches a command, accepts LEN
//  (a,b) operand pairs over valid/ready, accumulates a*b, presents the result over valid/ready.

---
 rtl/tt_dot_pkg.sv | 15 +
 rtl/tt_dot_sequencer_if.sv | 32 +++
 rtl/tt_mac_unit.sv | 29 ++
 rtl/tt_dot_sequencer.sv | 113 +++++++++++
 tb/tb_tt_dot_sequencer.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/tt_dot_pkg.sv
// Shared types and elaboration helpers for the dot-product sequencer.
package tt_dot_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Smallest accumulator that cannot overflow for MAX_LEN full-scale products.
  function automatic int acc_min_w(input int data_w, input int max_len);
    return 2 * data_w + $clog2(max_len);
  endfunction

endpackage

// File: rtl/tt_dot_sequencer_if.sv
// Command / operand / result handshake bundle for tt_dot_sequencer.
interface tt_dot_sequencer_if #(
  parameter int DATA_W  = 8,
  parameter int MAX_LEN = 16,
  parameter int ACC_W   = 20
);
  localparam int LEN_W = $clog2(MAX_LEN) + 1;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [LEN_W-1:0]  cmd_len;
  logic              cmd_signed;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_acc;
  logic              out_err;
  logic              busy;

  modport master (
    output cmd_valid, cmd_len, cmd_signed, in_valid, in_a, in_b, out_ready,
    input  cmd_ready, in_ready, out_valid, out_acc, out_err, busy
  );

  modport slave (
    input  cmd_valid, cmd_len, cmd_signed, in_valid, in_a, in_b, out_ready,
    output cmd_ready, in_ready, out_valid, out_acc, out_err, busy
  );
endinterface

// File: rtl/tt_mac_unit.sv
// Combinational multiply-accumulate: acc_o = acc_i + ext(a_i * b_i).
module tt_mac_unit #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              signed_i,
  input  logic [ACC_W-1:0]  acc_i,
  output logic [ACC_W-1:0]  acc_o
);

  logic signed [2*DATA_W-1:0] prod_s;
  logic        [2*DATA_W-1:0] prod_u;

  // Sign- or zero-extend the full-width product into the accumulator width.
  function automatic logic [ACC_W-1:0] ext_prod(input logic signed [2*DATA_W-1:0] ps,
                                                input logic [2*DATA_W-1:0] pu,
                                                input logic is_signed);
    logic signed [ACC_W-1:0] ext_s;
    ext_s = ACC_W'(ps);
    return is_signed ? ACC_W'(ext_s) : ACC_W'(pu);
  endfunction

  assign prod_s = $signed(a_i) * $signed(b_i);
  assign prod_u = a_i * b_i;
  assign acc_o  = acc_i + ext_prod(prod_s, prod_u, signed_i);

endmodule

// File: rtl/tt_dot_sequencer.sv
// Dot-product sequencer: latches a command, accumulates LEN operand pairs
// through a shared MAC, and presents the result over valid/ready.
module tt_dot_sequencer
  import tt_dot_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int MAX_LEN = 16,
  parameter int ACC_W   = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  tt_dot_sequencer_if.slave  bus
);

  localparam int LEN_W = $clog2(MAX_LEN) + 1;

  if (MAX_LEN < 1) begin : g_bad_len
    $error("tt_dot_sequencer: MAX_LEN must be >= 1");
  end
  if (ACC_W < acc_min_w(DATA_W, MAX_LEN)) begin : g_bad_acc_w
    $error("tt_dot_sequencer: ACC_W too narrow for DATA_W/MAX_LEN");
  end

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic               signed_q, signed_d;
  logic               err_q, err_d;
  logic [ACC_W-1:0]   mac_sum;

  tt_mac_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .a_i      (bus.in_a),
    .b_i      (bus.in_b),
    .signed_i (signed_q),
    .acc_i    (acc_q),
    .acc_o    (mac_sum)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    signed_d = signed_q;
    err_d    = err_q;

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          signed_d = bus.cmd_signed;
          acc_d    = '0;
          err_d    = 1'b0;
          if (bus.cmd_len == '0) begin
            state_d = DONE;
          end else if (bus.cmd_len > LEN_W'(MAX_LEN)) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            rem_d   = bus.cmd_len;
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (bus.in_valid) begin
          acc_d = mac_sum;
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides any handshake completing in the same cycle.
    if (clr) begin
      state_d = IDLE;
      acc_d   = '0;
      rem_d   = '0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      rem_q    <= '0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      signed_q <= signed_d;
      err_q    <= err_d;
    end
  end

  // Handshake outputs decode registered state only.
  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_acc   = acc_q;
  assign bus.out_err   = err_q;

endmodule

// File: tb/tb_tt_dot_sequencer.sv
// Scoreboard bench for tt_dot_sequencer: directed commands push expected
// results; a monitor pops and compares on every result handshake.
module tb_tt_dot_sequencer;

  localparam int DATA_W  = 8;
  localparam int MAX_LEN = 16;
  localparam int ACC_W   = 20;
  localparam int LEN_W   = $clog2(MAX_LEN) + 1;
  localparam int TMO     = 200;

  logic clk = 1'b0;
  logic rst_n;
  logic clr;

  always #5 clk = ~clk;

  tt_dot_sequencer_if #(.DATA_W(DATA_W), .MAX_LEN(MAX_LEN), .ACC_W(ACC_W)) bus ();

  tt_dot_sequencer #(.DATA_W(DATA_W), .MAX_LEN(MAX_LEN), .ACC_W(ACC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus)
  );

  typedef struct packed {
    logic [ACC_W-1:0] acc;
    logic             err;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: handshake not seen within %0d cycles, required handshake", name, TMO);
  endtask

  task automatic push_exp(input logic [ACC_W-1:0] acc, input logic err);
    exp_t e;
    e.acc = acc;
    e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_result: got acc %0d err %0d, required no result", bus.out_acc, bus.out_err);
        end else begin
          e = exp_q.pop_front();
          chk("out_acc", 32'(bus.out_acc), 32'(e.acc));
          chk("out_err", 32'(bus.out_err), 32'(e.err));
        end
      end
    end
  endtask

  task automatic send_cmd(input int len, input bit sgn);
    int t = 0;
    bus.cmd_valid  = 1'b1;
    bus.cmd_len    = LEN_W'(len);
    bus.cmd_signed = sgn;
    do begin @(negedge clk); t++; end while (!bus.cmd_ready && t < TMO);
    if (!bus.cmd_ready) timeout_fail("cmd_handshake");
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic send_pair(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input int gap);
    int t = 0;
    repeat (gap) begin @(posedge clk); #1; end
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    do begin @(negedge clk); t++; end while (!bus.in_ready && t < TMO);
    if (!bus.in_ready) timeout_fail("in_handshake");
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic recv();
    int t = 0;
    bus.out_ready = 1'b1;
    do begin @(negedge clk); t++; end while (!bus.out_valid && t < TMO);
    if (!bus.out_valid) timeout_fail("out_handshake");
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd0);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_out_acc"},   32'(bus.out_acc),   32'd0);
    chk({tag, "_out_err"},   32'(bus.out_err),   32'd0);
    chk({tag, "_busy"},      32'(bus.busy),      32'd0);
  endtask

  task automatic stimulus();
    rst_n = 1'b0; clr = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_len = '0; bus.cmd_signed = 1'b0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // len=3 unsigned: 6 + 20 + 65025
    push_exp(20'd65051, 1'b0);
    send_cmd(3, 1'b0);
    send_pair(8'd2, 8'd3, 0);
    send_pair(8'd4, 8'd5, 0);
    send_pair(8'd255, 8'd255, 0);
    chk("len3_out_valid_latency", 32'(bus.out_valid), 32'd1);
    recv();

    // len=2 signed: 16384 + (-127)
    push_exp(20'd16257, 1'b0);
    send_cmd(2, 1'b1);
    send_pair(8'h80, 8'h80, 0);
    send_pair(8'hFF, 8'h7F, 1);
    recv();

    // len=1 signed: 127 * -128 = -16256 -> 0xFC080 in 20 bits
    push_exp(20'hFC080, 1'b0);
    send_cmd(1, 1'b1);
    send_pair(8'h7F, 8'h80, 0);
    recv();

    // len=0: result ready the cycle after the command
    push_exp(20'd0, 1'b0);
    send_cmd(0, 1'b0);
    chk("len0_out_valid_next", 32'(bus.out_valid), 32'd1);
    recv();

    // len=17: rejected, no operands taken
    push_exp(20'd0, 1'b1);
    send_cmd(17, 1'b0);
    repeat (3) begin
      chk("len17_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
    end
    recv();

    // len=16 of 255*255 with random gaps, result held under backpressure
    push_exp(20'd1040400, 1'b0);
    send_cmd(16, 1'b0);
    for (int i = 0; i < 16; i++) send_pair(8'd255, 8'd255, int'($urandom_range(0, 2)));
    repeat (5) begin
      chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_out_acc",   32'(bus.out_acc),   32'd1040400);
      @(posedge clk); #1;
    end
    recv();

    // clr coincident with the third pair handshake of a len=4 command
    send_cmd(4, 1'b0);
    send_pair(8'd1, 8'd1, 0);
    send_pair(8'd2, 8'd2, 0);
    bus.in_valid = 1'b1; bus.in_a = 8'd3; bus.in_b = 8'd3; clr = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; clr = 1'b0;
    chk("clr_busy",      32'(bus.busy),      32'd0);
    chk("clr_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("clr_out_valid", 32'(bus.out_valid), 32'd0);
    push_exp(20'd1, 1'b0);
    send_cmd(1, 1'b0);
    send_pair(8'd1, 8'd1, 0);
    recv();

    // Asynchronous reset while a result is pending
    send_cmd(1, 1'b0);
    send_pair(8'd5, 8'd5, 0);
    chk("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    fork
      monitor();
      stimulus();
      begin
        repeat (20000) @(posedge clk);
        n_vec++;
        n_err++;
        $display("FAIL watchdog: run exceeded 20000 cycles, required completion");
      end
    join_any
    disable fork;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
